// File: rtl/output_port_scheduler.sv
// Output port scheduler: round-robin arbiter that locks one input onto the
// output for a whole packet, gated by downstream credits, with a stall
// watchdog that frees the port when a locked packet stops moving.
module output_port_scheduler #(
  parameter int          NUM_REQ   = 3,
  parameter int          BUF_DEPTH = 4,
  parameter int          TIMEOUT   = 16,
  parameter logic [2:0]  HEAD_CODE = 3'b001,
  parameter logic [2:0]  TAIL_CODE = 3'b100,
  localparam int         CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [3*NUM_REQ-1:0]   i_flit_type,
  input  logic                   i_credit_in,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic [2:0]             o_sel,
  output logic                   o_idle,
  output logic                   o_fire,
  output logic [CW-1:0]          o_credit_cnt,
  output logic                   o_timeout_err,
  output logic                   o_credit_err
);

  // Header flits carry no control meaning here; only the tail ends a lock.
  localparam logic [2:0] HDR = HEAD_CODE;

  localparam int SW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [2:0]          r_sel;
  logic [2:0]          r_rr_last;
  logic [CW-1:0]       r_credit_cnt;
  logic [SW-1:0]       r_stall_cnt;
  logic                r_timeout_err;
  logic                r_credit_err;

  logic                w_found;
  logic [2:0]          w_win;
  logic [2:0]          w_cur_type;
  logic                w_fire;
  logic                w_is_tail;
  logic                w_is_head;

  // Round-robin search starting just after the last served input.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && i_req[(int'(r_rr_last) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = 3'((int'(r_rr_last) + k) % NUM_REQ);
      end
    end
  end

  // Flit type of the currently granted input.
  always_comb begin
    w_cur_type = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_sel == 3'(i)) w_cur_type = i_flit_type[3*i +: 3];
    end
  end

  assign w_fire    = (r_state == S_LOCKED) && (|(r_gnt & i_req)) && (r_credit_cnt != '0);
  // A code equal to both HEAD and TAIL is treated as a tail (single-flit packet).
  assign w_is_head = (w_cur_type == HDR);
  assign w_is_tail = (w_cur_type == TAIL_CODE) || (w_is_head && (HDR == TAIL_CODE));

  // Grant FSM with watchdog: arbitrate in IDLE, hold the lock until a tail fires or the packet stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_gnt         <= '0;
      r_sel         <= '0;
      r_rr_last     <= 3'(NUM_REQ - 1);
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stall_cnt <= '0;
          if (w_found) begin
            r_state <= S_LOCKED;
            r_gnt   <= NUM_REQ'(1) << w_win;
            r_sel   <= w_win;
          end
        end
        S_LOCKED: begin
          if (w_fire) begin
            r_stall_cnt <= '0;
            if (w_is_tail) begin
              r_state   <= S_IDLE;
              r_gnt     <= '0;
              r_rr_last <= r_sel;
            end
          end else if (r_stall_cnt == SW'(TIMEOUT - 1)) begin
            r_state       <= S_IDLE;
            r_gnt         <= '0;
            r_rr_last     <= r_sel;
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b1;
          end else begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Credit counter mirrors free downstream slots; overflow is flagged sticky.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credit_cnt <= CW'(BUF_DEPTH);
      r_credit_err <= 1'b0;
    end else if (w_fire && !i_credit_in) begin
      r_credit_cnt <= r_credit_cnt - 1'b1;
    end else if (i_credit_in && !w_fire) begin
      if (r_credit_cnt == CW'(BUF_DEPTH)) r_credit_err <= 1'b1;
      else                                r_credit_cnt <= r_credit_cnt + 1'b1;
    end
  end

  assign o_gnt         = r_gnt;
  assign o_sel         = r_sel;
  assign o_idle        = (r_state == S_IDLE);
  assign o_fire        = w_fire;
  assign o_credit_cnt  = r_credit_cnt;
  assign o_timeout_err = r_timeout_err;
  assign o_credit_err  = r_credit_err;

endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// packet-level reference model.
module tb_output_port_scheduler;
  localparam int N  = 3;
  localparam int BD = 4;
  localparam int TO = 16;
  localparam logic [2:0] HD = 3'b001, PL = 3'b010, TL = 3'b100;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] ft = '0;
  logic           cin = 1'b0;
  logic [N-1:0]   gnt;
  logic [2:0]     sel;
  logic           idle, fire, terr, cerr;
  logic [2:0]     cred;

  int n_pass = 0, n_total = 0, n_fail = 0;

  output_port_scheduler #(.NUM_REQ(N), .BUF_DEPTH(BD), .TIMEOUT(TO),
                          .HEAD_CODE(HD), .TAIL_CODE(TL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_flit_type(ft),
    .i_credit_in(cin), .o_gnt(gnt), .o_sel(sel), .o_idle(idle),
    .o_fire(fire), .o_credit_cnt(cred), .o_timeout_err(terr),
    .o_credit_err(cerr));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3*N-1:0] ft1(input int i, input logic [2:0] c);
    logic [3*N-1:0] f;
    f = '0;
    f[3*i +: 3] = c;
    return f;
  endfunction

  // Apply one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic step(input logic [N-1:0] r, input logic [3*N-1:0] f, input logic c);
    @(posedge clk); #1;
    req = r; ft = f; cin = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req = '0; ft = '0; cin = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Owner is the granted input (-1 when the port is free). Quiet cycles are
  // measured as the distance from the first cycle after the lock started or
  // after the last transfer.
  int m_owner = -1, m_last = N - 1, m_cred = BD, m_anchor = 0, cyc = 0;
  bit m_cerr = 1'b0, m_terr = 1'b0;

  always @(negedge clk) begin
    bit f, nt;
    int eg, idx;
    cyc++;
    if (!rst_n) begin
      m_owner = -1; m_last = N - 1; m_cred = BD; m_cerr = 0; m_terr = 0;
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_idle", int'(idle), 1);
      chk("rst_cred", int'(cred), BD);
      chk("rst_fire", int'(fire), 0);
      chk("rst_terr", int'(terr), 0);
      chk("rst_cerr", int'(cerr), 0);
      chk("rst_sel", int'(sel), 0);
    end else begin
      f  = (m_owner >= 0) && req[m_owner] && (m_cred > 0);
      eg = (m_owner >= 0) ? (1 << m_owner) : 0;
      chk("m_gnt", int'(gnt), eg);
      chk("m_idle", int'(idle), (m_owner < 0) ? 1 : 0);
      chk("m_fire", int'(fire), int'(f));
      chk("m_cred", int'(cred), m_cred);
      chk("m_terr", int'(terr), int'(m_terr));
      chk("m_cerr", int'(cerr), int'(m_cerr));
      if (m_owner >= 0) chk("m_sel", int'(sel), m_owner);
      nt = 0;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (m_owner < 0 && req[idx]) begin
            m_owner  = idx;
            m_anchor = cyc + 1;
          end
        end
      end else if (f) begin
        m_anchor = cyc + 1;
        if (ft[3*m_owner +: 3] == TL) begin m_last = m_owner; m_owner = -1; end
      end else if (cyc - m_anchor == TO - 1) begin
        m_last = m_owner; m_owner = -1; nt = 1;
      end
      m_terr = nt;
      if (f && !cin) m_cred--;
      else if (cin && !f) begin
        if (m_cred == BD) m_cerr = 1;
        else m_cred++;
      end
    end
  end

  // ---------------- stimulus and literal checks ----------------
  initial begin
    int n;
    logic [N-1:0]   r;
    logic [3*N-1:0] f;
    int exp_seq [8] = '{0, 1, 0, 2, 0, 4, 0, 1};
    int rq, cp, tp;

    // T1: reset with all inputs requesting
    req = '1; ft = {TL, TL, TL};
    @(negedge clk);
    chk("t1_gnt", int'(gnt), 0);
    chk("t1_idle", int'(idle), 1);
    chk("t1_cred", int'(cred), 4);
    chk("t1_fire", int'(fire), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("t1_arb_cycle_gnt", int'(gnt), 0);
    step('1, {TL, TL, TL}, 0);
    chk("t1_first_gnt", int'(gnt), 1);
    chk("t1_first_fire", int'(fire), 1);

    // T2: three-flit packet from input 1
    do_reset();
    step(3'b010, ft1(1, HD), 0);
    chk("t2_idle0", int'(idle), 1);
    step(3'b010, ft1(1, HD), 0);
    chk("t2_gnt", int'(gnt), 2);
    chk("t2_sel", int'(sel), 1);
    chk("t2_fire_h", int'(fire), 1);
    step(3'b010, ft1(1, PL), 0);
    chk("t2_fire_p", int'(fire), 1);
    step(3'b010, ft1(1, TL), 0);
    chk("t2_fire_t", int'(fire), 1);
    chk("t2_cred_mid", int'(cred), 2);
    step('0, '0, 0);
    chk("t2_idle_end", int'(idle), 1);
    chk("t2_cred_end", int'(cred), 1);

    // T5: fire and credit together, then overflow
    step('0, '0, 1);
    step(3'b001, ft1(0, TL), 0);
    chk("t5_cred_a", int'(cred), 2);
    step(3'b001, ft1(0, TL), 1);
    chk("t5_fire", int'(fire), 1);
    step('0, '0, 0);
    chk("t5_cred_same", int'(cred), 2);
    step('0, '0, 1);
    step('0, '0, 1);
    step('0, '0, 1);
    chk("t5_cred_full", int'(cred), 4);
    chk("t5_cerr_pre", int'(cerr), 0);
    step('0, '0, 0);
    chk("t5_cerr", int'(cerr), 1);
    chk("t5_cred_held", int'(cred), 4);

    // T4: credit exhaustion on a long packet
    do_reset();
    step(3'b001, ft1(0, PL), 0);
    for (int i = 0; i < 4; i++) begin
      step(3'b001, ft1(0, PL), 0);
      chk("t4_fire_run", int'(fire), 1);
    end
    step(3'b001, ft1(0, PL), 0);
    chk("t4_nofire", int'(fire), 0);
    chk("t4_cred0", int'(cred), 0);
    step(3'b001, ft1(0, PL), 1);
    chk("t4_wait", int'(fire), 0);
    step(3'b001, ft1(0, PL), 0);
    chk("t4_refire", int'(fire), 1);
    chk("t4_cred1", int'(cred), 1);
    step(3'b001, ft1(0, TL), 0);
    chk("t4_cred_back0", int'(cred), 0);

    // T3: round-robin order with one idle cycle between grants
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step('1, {TL, TL, TL}, 0);
      chk("t3_rr_gnt", int'(gnt), exp_seq[k]);
    end

    // T6: watchdog releases a stalled grant
    do_reset();
    step(3'b010, ft1(1, HD), 0);
    step(3'b010, ft1(1, HD), 0);
    chk("t6_fire", int'(fire), 1);
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      step(3'b100, '0, 0);
      if (terr) begin n = i; break; end
    end
    chk("t6_timeout_delay", n, 17);
    chk("t6_idle", int'(idle), 1);
    chk("t6_gnt0", int'(gnt), 0);
    step(3'b100, '0, 0);
    chk("t6_next_gnt", int'(gnt), 4);

    // Randomized traffic in phases of differing load
    for (int ph = 0; ph < 12; ph++) begin
      rq = $urandom_range(5, 95);
      cp = (ph % 4 == 0) ? 0 : $urandom_range(10, 80);
      tp = $urandom_range(10, 60);
      for (int c = 0; c < 250; c++) begin
        for (int i = 0; i < N; i++) begin
          r[i] = ($urandom_range(0, 99) < rq);
          if ($urandom_range(0, 99) < tp) f[3*i +: 3] = TL;
          else f[3*i +: 3] = ($urandom_range(0, 1) != 0) ? HD : PL;
        end
        if ($urandom_range(0, 599) == 0) begin
          @(posedge clk); #1; rst_n = 1'b0;
          @(negedge clk);
          @(posedge clk); #1; rst_n = 1'b1;
        end
        step(r, f, ($urandom_range(0, 99) < cp));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
